// File: rtl/tcdm_pkg.sv
// Shared TCDM definitions: write-enable encoding and occupancy-counter sizing
// for the request/response buffers.
package tcdm_pkg;

    localparam logic TCDM_WEN_STORE = 1'b0;
    localparam logic TCDM_WEN_LOAD  = 1'b1;

    // Counter must represent 0..depth inclusive.
    function automatic int unsigned tcdm_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tcdm_fifo_ctrl.sv
// Circular-buffer bookkeeping: read/write pointers, occupancy, full/empty.
// Flush returns everything to the empty state and overrides push/pop.
module tcdm_fifo_ctrl
    import tcdm_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = tcdm_cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/tcdm_req_fifo.sv
// DEPTH-entry TCDM request buffer between an initiator and one SRAM bank.
// Head entry is presented from the cycle after it is pushed; outputs read 0 while empty.
module tcdm_req_fifo
    import tcdm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 11,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SRAM_ADDR_WIDTH = 11,
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned GNT_PASSTHRU    = 0,
    localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    localparam int unsigned PTR_W          = $clog2(DEPTH),
    localparam int unsigned CNT_W          = tcdm_cnt_width(DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       data_req_i,
    input  logic [ADDR_WIDTH-1:0]      data_add_i,
    input  logic                       data_wen_i,
    input  logic [DATA_WIDTH-1:0]      data_wdata_i,
    input  logic [BE_WIDTH-1:0]        data_be_i,
    output logic                       data_gnt_o,
    output logic                       data_req_SRAM_o,
    output logic [SRAM_ADDR_WIDTH-1:0] data_add_SRAM_o,
    output logic                       data_wen_SRAM_o,
    output logic [DATA_WIDTH-1:0]      data_wdata_SRAM_o,
    output logic [BE_WIDTH-1:0]        data_be_SRAM_o,
    input  logic                       data_gnt_i,
    output logic [CNT_W-1:0]           count_o
);

    logic [SRAM_ADDR_WIDTH-1:0] add_q   [DEPTH];
    logic                       wen_q   [DEPTH];
    logic [DATA_WIDTH-1:0]      wdata_q [DEPTH];
    logic [BE_WIDTH-1:0]        be_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty;
    logic             push, pop;
    logic             passthru_gnt;
    logic [DEPTH-1:0] we;

    // In pass-through mode data_gnt_i reaches data_gnt_o combinationally.
    assign passthru_gnt = (GNT_PASSTHRU != 0) & data_gnt_i;
    assign data_gnt_o   = ~flush_i & (~full | passthru_gnt);
    assign push         = data_req_i & data_gnt_o;
    assign pop          = ~empty & data_gnt_i;

    tcdm_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) i_ctrl (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .push_i   (push),
        .pop_i    (pop),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .count_o  (count_o),
        .full_o   (full),
        .empty_o  (empty)
    );

    always_comb begin
        we         = '0;
        we[wr_ptr] = push;
    end

    // Storage is deliberately unreset; the empty gating hides stale contents.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (we[i]) begin
                add_q[i]   <= data_add_i[SRAM_ADDR_WIDTH-1:0];
                wen_q[i]   <= data_wen_i;
                wdata_q[i] <= data_wdata_i;
                be_q[i]    <= data_be_i;
            end
        end
    end

    always_comb begin
        data_req_SRAM_o   = ~empty;
        data_add_SRAM_o   = '0;
        data_wen_SRAM_o   = TCDM_WEN_STORE;
        data_wdata_SRAM_o = '0;
        data_be_SRAM_o    = '0;
        if (!empty) begin
            data_add_SRAM_o   = add_q[rd_ptr];
            data_wen_SRAM_o   = wen_q[rd_ptr];
            data_wdata_SRAM_o = wdata_q[rd_ptr];
            data_be_SRAM_o    = be_q[rd_ptr];
        end
    end

    if (SRAM_ADDR_WIDTH < ADDR_WIDTH) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^data_add_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH];
    end

endmodule
